// File: rtl/comp_set_pipe.sv
// comp_set_pipe: pipelined compare-and-set unit with a valid/ready handshake.
// Produces z = {0..0, hit} plus registered less/equal flags. PIPE selects
// one or two register stages. Ready propagates combinationally one level back.
module comp_set_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    input  logic             sign_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             flag_less,
    output logic             flag_eql
);

    // Signed compare = unsigned compare with both MSBs flipped.
    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic             cmp_less;
    logic             cmp_eql;
    logic             hit_q;
    logic             out_adv;

    assign a_cmp    = {a[WIDTH-1] ^ sign_en, a[WIDTH-2:0]};
    assign b_cmp    = {b[WIDTH-1] ^ sign_en, b[WIDTH-2:0]};
    assign cmp_less = a_cmp < b_cmp;
    assign cmp_eql  = a == b;

    // Output stage may take new data when empty or being drained this cycle.
    assign out_adv = !out_valid || out_ready;

    assign z = {{(WIDTH-1){1'b0}}, hit_q};

    // Compare-code decode: ctrl[2] selects equality tests, ctrl[1:0] orders.
    function automatic logic decode(input logic less, input logic eql,
                                    input logic [2:0] code);
        logic h;
        h = 1'b0;
        if (code[2]) begin
            h = code[0] ? !eql : eql;
        end else begin
            case (code[1:0])
                2'b00:   h = !less && !eql;
                2'b01:   h = !less;
                2'b10:   h = less;
                default: h = less || eql;
            endcase
        end
        return h;
    endfunction

    generate
        if (PIPE == 1) begin : g_pipe1
            assign in_ready = out_adv;

            // Single output register: compare and decode in the same cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    hit_q     <= 1'b0;
                    flag_less <= 1'b0;
                    flag_eql  <= 1'b0;
                end else begin
                    if (out_adv) out_valid <= in_valid;
                    if (in_valid && out_adv) begin
                        hit_q     <= decode(cmp_less, cmp_eql, ctrl);
                        flag_less <= cmp_less;
                        flag_eql  <= cmp_eql;
                    end
                end
            end
        end else begin : g_pipe2
            logic       v1;
            logic       s1_less;
            logic       s1_eql;
            logic [2:0] s1_ctrl;

            // S1 is free when empty or when it hands off to S2 this cycle.
            assign in_ready = !v1 || out_adv;

            // Stage valids: each stage refills in the cycle it drains.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v1        <= 1'b0;
                    out_valid <= 1'b0;
                end else begin
                    if (in_ready) v1        <= in_valid;
                    if (out_adv)  out_valid <= v1;
                end
            end

            // S1 captures the raw compare result and the code to decode.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_less <= 1'b0;
                    s1_eql  <= 1'b0;
                    s1_ctrl <= 3'b000;
                end else if (in_valid && in_ready) begin
                    s1_less <= cmp_less;
                    s1_eql  <= cmp_eql;
                    s1_ctrl <= ctrl;
                end
            end

            // S2 decodes and holds the result while the consumer stalls.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hit_q     <= 1'b0;
                    flag_less <= 1'b0;
                    flag_eql  <= 1'b0;
                end else if (v1 && out_adv) begin
                    hit_q     <= decode(s1_less, s1_eql, s1_ctrl);
                    flag_less <= s1_less;
                    flag_eql  <= s1_eql;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_comp_set_pipe.sv
// tb_comp_set_pipe: drives a PIPE=1 and a PIPE=2 instance with one shared
// stimulus stream; each instance has its own queue of expected results.
module tb_comp_set_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   ctrl = 3'b000;
    logic         sign_en = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready  [2];
    logic         out_valid [2];
    logic         flag_less [2];
    logic         flag_eql  [2];
    logic [W-1:0] z         [2];

    int errors = 0;
    int checks = 0;

    logic [2:0]   sb [2][$];      // {hit, less, eql} in acceptance order
    logic         stall   [2];
    logic [W-1:0] stall_z [2];

    always #5 clk = ~clk;

    comp_set_pipe #(.WIDTH(W), .PIPE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .ctrl(ctrl), .sign_en(sign_en),
        .out_valid(out_valid[0]), .out_ready(out_ready), .z(z[0]),
        .flag_less(flag_less[0]), .flag_eql(flag_eql[0]));

    comp_set_pipe #(.WIDTH(W), .PIPE(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .ctrl(ctrl), .sign_en(sign_en),
        .out_valid(out_valid[1]), .out_ready(out_ready), .z(z[1]),
        .flag_less(flag_less[1]), .flag_eql(flag_eql[1]));

    // Reference: compare as integers, then apply the relation named by ctrl.
    function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] c, input logic s);
        longint sx, sy;
        logic h;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        case (c)
            3'd0:       h = sx > sy;
            3'd1:       h = sx >= sy;
            3'd2:       h = sx < sy;
            3'd3:       h = sx <= sy;
            3'd4, 3'd6: h = (x == y);
            default:    h = (x != y);
        endcase
        return {h, sx < sy, x == y};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_out_valid_p%0d", tag, d + 1), out_valid[d], 0);
            check($sformatf("%s_z_p%0d", tag, d + 1), z[d], 0);
            check($sformatf("%s_flag_less_p%0d", tag, d + 1), flag_less[d], 0);
            check($sformatf("%s_flag_eql_p%0d", tag, d + 1), flag_eql[d], 0);
            check($sformatf("%s_in_ready_p%0d", tag, d + 1), in_ready[d], 1);
        end
    endtask

    // One clock: observe handshakes just before the edge, then advance.
    task automatic cyc();
        logic [2:0] e;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (stall[d]) begin
                check($sformatf("hold_valid_p%0d", d + 1), out_valid[d], 1);
                check($sformatf("hold_z_p%0d", d + 1), z[d], stall_z[d]);
            end
            if (out_valid[d] && out_ready) begin
                if (sb[d].size() == 0) begin
                    check($sformatf("spurious_out_p%0d", d + 1), out_valid[d], 0);
                end else begin
                    e = sb[d].pop_front();
                    check($sformatf("z_p%0d", d + 1), z[d], {31'd0, e[2]});
                    check($sformatf("flag_less_p%0d", d + 1), flag_less[d], e[1]);
                    check($sformatf("flag_eql_p%0d", d + 1), flag_eql[d], e[0]);
                end
            end
            stall[d]   = out_valid[d] && !out_ready;
            stall_z[d] = z[d];
            if (in_valid && in_ready[d]) sb[d].push_back(model(a, b, ctrl, sign_en));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        for (int d = 0; d < 2; d++)
            check($sformatf("drained_p%0d", d + 1), sb[d].size(), 0);
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] c, input logic s);
        in_valid = 1'b1;
        a = x;
        b = y;
        ctrl = c;
        sign_en = s;
    endtask

    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    logic [W-1:0] edge_v [5];

    initial begin
        stall   = '{1'b0, 1'b0};
        stall_z = '{'0, '0};
        pa = '{32'd3, 32'd5, 32'd5};
        pb = '{32'd5, 32'd5, 32'd3};
        edge_v = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

        // Reset state
        #2;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single transaction, latency 1 vs 2
        out_ready = 1'b1;
        drive(32'd5, 32'd3, 3'b000, 1'b0);
        cyc();
        in_valid = 1'b0;
        check("t1_p1_valid", out_valid[0], 1);
        check("t1_p1_z", z[0], 32'h1);
        check("t1_p2_valid_early", out_valid[1], 0);
        cyc();
        check("t1_p2_valid", out_valid[1], 1);
        check("t1_p2_z", z[1], 32'h1);
        check("t1_p2_less", flag_less[1], 0);
        check("t1_p2_eql", flag_eql[1], 0);
        cyc();
        drain();

        // All compare codes over less / equal / greater operand pairs
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 8; c++) begin
                drive(pa[p], pb[p], 3'(c), 1'b0);
                cyc();
            end
        drain();

        // Signed vs unsigned on -1 < 1
        drive(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("signed_lt_z", z[1], 32'h1);
        cyc();
        drive(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("unsigned_lt_z", z[1], 32'h0);
        drain();

        // Backpressure on the two-stage instance
        out_ready = 1'b0;
        drive(32'd5, 32'd3, 3'b000, 1'b0);
        cyc();
        check("bp_ready_after_1st", in_ready[1], 1);
        drive(32'd9, 32'd2, 3'b010, 1'b0);
        cyc();
        check("bp_ready_after_2nd", in_ready[1], 0);
        drive(32'd7, 32'd7, 3'b100, 1'b0);
        repeat (4) begin
            cyc();
            check("bp_hold_z", z[1], 32'h1);
            check("bp_ready_low", in_ready[1], 0);
        end
        out_ready = 1'b1;
        check("bp_rel_valid0", out_valid[1], 1);
        cyc();
        in_valid = 1'b0;
        check("bp_rel_valid1", out_valid[1], 1);
        cyc();
        check("bp_rel_valid2", out_valid[1], 1);
        cyc();
        check("bp_rel_empty", out_valid[1], 0);
        drain();

        // Throughput: 16 back-to-back transactions
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                drive($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                check("tp_ready_p1", in_ready[0], 1);
                check("tp_ready_p2", in_ready[1], 1);
            end else begin
                in_valid = 1'b0;
            end
            cyc();
            check($sformatf("tp_valid_p1_c%0d", i), out_valid[0], (i < 16) ? 1 : 0);
            check($sformatf("tp_valid_p2_c%0d", i), out_valid[1], (i >= 1 && i < 17) ? 1 : 0);
        end
        drain();

        // Asynchronous reset with both stages occupied
        out_ready = 1'b0;
        drive(32'd1, 32'd2, 3'b011, 1'b0);
        cyc();
        drive(32'd4, 32'd4, 3'b101, 1'b0);
        cyc();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        for (int d = 0; d < 2; d++) begin
            sb[d].delete();
            stall[d] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            check("post_rst_no_stale_p1", out_valid[0], 0);
            check("post_rst_no_stale_p2", out_valid[1], 0);
        end
        drive(32'hFFFF_FFFE, 32'h0000_0002, 3'b011, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("post_rst_txn_valid", out_valid[1], 1);
        check("post_rst_txn_z", z[1], 32'h1);
        drain();

        // Random traffic with random stalls and boundary operands
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [W-1:0] x, y;
            sel = $urandom_range(0, 3);
            x = $urandom;
            y = $urandom;
            if (sel == 0) y = x;
            else if (sel == 1) begin
                x = edge_v[$urandom_range(0, 4)];
                y = edge_v[$urandom_range(0, 4)];
            end
            drive(x, y, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
